ripple_count_sampler: RTL

- Sits directly downstream of the 4-bit asynchronous ripple up-counter.
- Samples the counter's glitch-prone output into the `clk` domain through a two-flop synchronizer and a settling filter.
- Extends the filtered value to a wide binary count by detecting wrap-around.
- Exposes the count live and through a valid/ready snapshot port for software or a downstream consumer.

---
 rtl/ripple_count_sampler.sv | 105 ++++++++++
 1 files changed

// File: rtl/ripple_count_sampler.sv
// Samples a 4-bit asynchronous ripple counter into clk, filters settling glitches,
// extends it to a wide count by wrap detection, and offers a valid/ready snapshot.
// Optional missed-count detection is built when RCS_SKIP_CHECK_EN is defined.
module ripple_count_sampler #(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned EXT_W         = 12,
    localparam int unsigned CW           = 4 + EXT_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [3:0]    q_async,
    input  logic          snap_req,
    input  logic          snap_ready,
    output logic          snap_valid,
    output logic [CW-1:0] snap_count,
    output logic [CW-1:0] count,
    output logic          wrap_pulse,
    output logic          ext_overflow,
    output logic          skip_err
);

    localparam int unsigned SW = 4;

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       acc;
    logic [EXT_W-1:0] ext;
    logic [SW-1:0]    stab;
    logic             accept;
    logic             wrap;

    // stab holds the run length of s2 as registered, so acceptance sees a settled value
    assign accept = (stab >= SW'(STABLE_CYCLES)) && (s2 != acc);
    assign wrap   = accept && (s2 < acc);
    assign count  = {ext, acc};

    // Two-flop synchronizer and settling filter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 4'd0;
            s2   <= 4'd0;
            stab <= '0;
            acc  <= 4'd0;
        end else begin
            s1 <= q_async;
            s2 <= s1;
            if (s1 != s2) begin
                stab <= SW'(1);
            end else if (stab < SW'(STABLE_CYCLES)) begin
                stab <= stab + SW'(1);
            end
            if (accept) begin
                acc <= s2;
            end
        end
    end

    // Wrap extension
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext          <= '0;
            wrap_pulse   <= 1'b0;
            ext_overflow <= 1'b0;
        end else begin
            wrap_pulse <= wrap;
            if (wrap) begin
                ext <= ext + EXT_W'(1);
                if (ext == '1) begin
                    ext_overflow <= 1'b1;
                end
            end
        end
    end

    // Snapshot port; a request during a completing transfer recaptures immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_valid <= 1'b0;
            snap_count <= '0;
        end else if (!snap_valid || snap_ready) begin
            snap_valid <= snap_req;
            if (snap_req) begin
                snap_count <= count;
            end
        end
    end

`ifdef RCS_SKIP_CHECK_EN
    logic [3:0] delta;

    assign delta = s2 - acc;

    // Any accepted step other than +1 means the sampler missed a count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skip_err <= 1'b0;
        end else if (accept && (delta != 4'd1)) begin
            skip_err <= 1'b1;
        end
    end
`else
    assign skip_err = 1'b0;
`endif

endmodule
